// File: rtl/pump_ctrl_pkg.sv
// Shared types and constants for the pump controller slice.
package pump_ctrl_pkg;

    localparam int unsigned LVL_W = 8;

    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_ON      = 2'b01,
        ST_FAULT   = 2'b10,
        ST_CFG_ERR = 2'b11
    } pump_state_t;

    localparam logic PUMP_ON  = 1'b1;
    localparam logic PUMP_OFF = 1'b0;

    // A band with lo >= hi cannot produce hysteresis and is treated as misconfigured.
    function automatic logic cfg_invalid(input logic [LVL_W-1:0] lo,
                                         input logic [LVL_W-1:0] hi);
        return (lo >= hi);
    endfunction

endpackage

// File: rtl/pump_ctrl_fsm_stall.sv
// Dry-run monitor: counts ON cycles in which the registered level failed to rise.
module pump_stall_mon
    import pump_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CYC = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_active,
    input  logic [LVL_W-1:0] i_lvl,
    output logic             o_stall_expire
);

    localparam int unsigned   SC_W    = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STALL_CYC - 1);

    logic [LVL_W-1:0] r_prev_lvl;
    logic [SC_W-1:0]  r_stall_cnt;
    logic             w_rise;

    // Plain unsigned compare: a 255->0 wrap reads as a drop, not a rise.
    assign w_rise = (i_lvl > r_prev_lvl);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_lvl  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_prev_lvl <= i_lvl;
            if (!i_active || w_rise) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != SC_LAST) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_stall_expire = i_active && (r_stall_cnt == SC_LAST);

endmodule

// File: rtl/pump_ctrl_fsm.sv
// Pump sequencer: registered level/threshold inputs, four-state FSM with dwell,
// overfill trip and dry-run fault latch; all outputs are registered.
module pump_ctrl_fsm
    import pump_ctrl_pkg::*;
#(
    parameter int unsigned      MIN_DWELL = 16,
    parameter int unsigned      STALL_CYC = 64,
    parameter logic [LVL_W-1:0] SAFE_MAX  = 8'd250,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             enable,
    input  logic [LVL_W-1:0] lo_thr,
    input  logic [LVL_W-1:0] hi_thr,
    input  logic             fault_clr,
    input  logic [LVL_W-1:0] water_lvl,
    output logic             water_trend,
    output logic [1:0]       state,
    output logic             fault,
    output logic             trip,
    output logic [CNT_W-1:0] start_cnt
);

    localparam int unsigned     DW_W      = $clog2(MIN_DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MIN_DWELL);

    pump_state_t      r_state;
    pump_state_t      w_next;
    logic [DW_W-1:0]  r_dwell;
    logic [LVL_W-1:0] r_lvl_q;
    logic [LVL_W-1:0] r_lo_q;
    logic [LVL_W-1:0] r_hi_q;
    logic             r_trend;
    logic             r_fault;
    logic             r_trip;
    logic [CNT_W-1:0] r_start_cnt;

    logic             w_cfg_bad;
    logic             w_dwell_done;
    logic             w_stall_expire;
    logic             w_trip;
    logic             w_start;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_lvl_q <= '0;
            r_lo_q  <= '0;
            // hi_q resets high so the empty lo/hi pair never flags a config error.
            r_hi_q  <= '1;
        end else begin
            r_lvl_q <= water_lvl;
            r_lo_q  <= lo_thr;
            r_hi_q  <= hi_thr;
        end
    end

    pump_stall_mon #(
        .STALL_CYC(STALL_CYC)
    ) u_stall_mon (
        .i_clk          (CLK100MHZ),
        .i_rst_n        (CPU_RESETN),
        .i_active       (r_state == ST_ON),
        .i_lvl          (r_lvl_q),
        .o_stall_expire (w_stall_expire)
    );

    assign w_cfg_bad    = cfg_invalid(r_lo_q, r_hi_q);
    assign w_dwell_done = (r_dwell == DWELL_MAX);

    always_comb begin
        w_next  = r_state;
        w_trip  = 1'b0;
        w_start = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_cfg_bad) begin
                    w_next = ST_CFG_ERR;
                end else if (enable && (r_lvl_q <= r_lo_q) && w_dwell_done &&
                             (r_lvl_q < SAFE_MAX)) begin
                    w_next  = ST_ON;
                    w_start = 1'b1;
                end
            end
            ST_ON: begin
                if (r_lvl_q >= SAFE_MAX) begin
                    w_next = ST_OFF;
                    w_trip = 1'b1;
                end else if (w_stall_expire) begin
                    w_next = ST_FAULT;
                end else if (w_cfg_bad) begin
                    w_next = ST_CFG_ERR;
                end else if (w_dwell_done && ((r_lvl_q >= r_hi_q) || !enable)) begin
                    w_next = ST_OFF;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    w_next = ST_OFF;
                end
            end
            ST_CFG_ERR: begin
                if (!w_cfg_bad) begin
                    w_next = ST_OFF;
                end
            end
            default: begin
                w_next = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state     <= ST_OFF;
            r_dwell     <= '0;
            r_trend     <= PUMP_OFF;
            r_fault     <= 1'b0;
            r_trip      <= 1'b0;
            r_start_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_dwell <= '0;
            end else if (!w_dwell_done) begin
                r_dwell <= r_dwell + 1'b1;
            end
            r_trend <= (w_next == ST_ON) ? PUMP_ON : PUMP_OFF;
            r_fault <= (w_next == ST_FAULT);
            r_trip  <= w_trip;
            if (w_start && (r_start_cnt != '1)) begin
                r_start_cnt <= r_start_cnt + 1'b1;
            end
        end
    end

    assign state       = r_state;
    assign water_trend = r_trend;
    assign fault       = r_fault;
    assign trip        = r_trip;
    assign start_cnt   = r_start_cnt;

endmodule

// File: tb/tb_pump_ctrl_fsm.sv
// Directed bench for pump_ctrl_fsm: the tank level is driven directly by the bench.
module tb_pump_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        fault_clr;
    logic [7:0]  lvl;
    logic        trend;
    logic [1:0]  state;
    logic        fault;
    logic        trip;
    logic [15:0] start_cnt;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] S_OFF = 2'b00;
    localparam logic [1:0] S_ON  = 2'b01;
    localparam logic [1:0] S_FLT = 2'b10;
    localparam logic [1:0] S_CFG = 2'b11;

    pump_ctrl_fsm #(
        .MIN_DWELL(16),
        .STALL_CYC(64),
        .SAFE_MAX (8'd250),
        .CNT_W    (16)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .enable     (enable),
        .lo_thr     (lo),
        .hi_thr     (hi),
        .fault_clr  (fault_clr),
        .water_lvl  (lvl),
        .water_trend(trend),
        .state      (state),
        .fault      (fault),
        .trip       (trip),
        .start_cnt  (start_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [1:0] exp_state, input logic exp_trend);
        chk({tag, "_state"}, 32'(state), 32'(exp_state));
        chk({tag, "_trend"}, 32'(trend), 32'(exp_trend));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; lo = 8'd20; hi = 8'd100; fault_clr = 1'b0; lvl = 8'd0;
        #3;
        chk_st("rst", S_OFF, 1'b0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_trip", 32'(trip), 32'd0);
        chk("rst_cnt", 32'(start_cnt), 32'd0);
        tick(2);
        rst_n = 1'b1;

        // First start needs the full dwell after reset.
        tick(16);
        chk_st("dwell0_hold", S_OFF, 1'b0);
        tick(1);
        chk_st("first_on", S_ON, 1'b1);
        chk("first_on_cnt", 32'(start_cnt), 32'd1);

        // Hysteresis: ramp up, stop exactly at hi with two-cycle latency.
        for (int i = 1; i <= 20; i++) begin
            lvl = 8'(4 * i);
            tick(1);
        end
        lvl = 8'd99;
        tick(2);
        chk_st("below_hi", S_ON, 1'b1);
        lvl = 8'd100;
        tick(1);
        chk_st("hi_lat1", S_ON, 1'b1);
        tick(1);
        chk_st("hi_stop", S_OFF, 1'b0);

        lvl = 8'd21;
        tick(20);
        chk_st("above_lo", S_OFF, 1'b0);
        lvl = 8'd20;
        tick(1);
        chk_st("lo_lat1", S_OFF, 1'b0);
        tick(1);
        chk_st("lo_start", S_ON, 1'b1);
        chk("lo_start_cnt", 32'(start_cnt), 32'd2);

        // Tight band: level past hi immediately, but dwell holds ON.
        lo = 8'd49; hi = 8'd50; lvl = 8'd60;
        tick(16);
        chk_st("tight_hold_on", S_ON, 1'b1);
        tick(1);
        chk_st("tight_off", S_OFF, 1'b0);
        lvl = 8'd49;
        tick(16);
        chk_st("tight_hold_off", S_OFF, 1'b0);
        tick(1);
        chk_st("tight_on", S_ON, 1'b1);
        chk("tight_cnt", 32'(start_cnt), 32'd3);

        // Overfill trip ignores dwell and pulses trip for one cycle.
        lo = 8'd20; hi = 8'd255; lvl = 8'd249;
        tick(3);
        chk_st("pre_trip", S_ON, 1'b1);
        lvl = 8'd250;
        tick(1);
        chk_st("trip_lat1", S_ON, 1'b1);
        chk("trip_lat1_pulse", 32'(trip), 32'd0);
        tick(1);
        chk_st("trip_off", S_OFF, 1'b0);
        chk("trip_pulse", 32'(trip), 32'd1);
        tick(1);
        chk("trip_end", 32'(trip), 32'd0);
        chk_st("trip_after", S_OFF, 1'b0);
        chk("trip_cnt", 32'(start_cnt), 32'd3);

        // Dry run: constant level while ON, fault_clr coincident with expiry.
        hi = 8'd100; lvl = 8'd10;
        tick(15);
        chk_st("dry_pre", S_OFF, 1'b0);
        tick(1);
        chk_st("dry_on", S_ON, 1'b1);
        chk("dry_on_cnt", 32'(start_cnt), 32'd4);
        tick(63);
        chk_st("dry_63", S_ON, 1'b1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk_st("dry_fault", S_FLT, 1'b0);
        chk("dry_fault_flag", 32'(fault), 32'd1);
        tick(3);
        chk_st("fault_hold", S_FLT, 1'b0);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk_st("fault_clr", S_OFF, 1'b0);
        chk("fault_clr_flag", 32'(fault), 32'd0);
        tick(16);
        chk_st("clr_hold", S_OFF, 1'b0);
        tick(1);
        chk_st("clr_on", S_ON, 1'b1);
        chk("clr_on_cnt", 32'(start_cnt), 32'd5);

        // Inverted thresholds while ON.
        lo = 8'd120; hi = 8'd80;
        tick(1);
        chk_st("cfg_lat1", S_ON, 1'b1);
        tick(1);
        chk_st("cfg_err", S_CFG, 1'b0);
        tick(5);
        chk_st("cfg_hold", S_CFG, 1'b0);
        lo = 8'd20; hi = 8'd100;
        tick(1);
        chk_st("cfg_fix_lat1", S_CFG, 1'b0);
        tick(1);
        chk_st("cfg_fix", S_OFF, 1'b0);

        // Enable gating in both directions.
        enable = 1'b0;
        tick(30);
        chk_st("en0_off", S_OFF, 1'b0);
        enable = 1'b1;
        tick(1);
        chk_st("en1_on", S_ON, 1'b1);
        chk("en1_cnt", 32'(start_cnt), 32'd6);
        enable = 1'b0;
        tick(16);
        chk_st("en0_hold", S_ON, 1'b1);
        tick(1);
        chk_st("en0_stop", S_OFF, 1'b0);

        // Asynchronous reset while pumping.
        enable = 1'b1;
        tick(16);
        chk_st("pre_rst_off", S_OFF, 1'b0);
        tick(1);
        chk_st("pre_rst_on", S_ON, 1'b1);
        chk("pre_rst_cnt", 32'(start_cnt), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_st("async_rst", S_OFF, 1'b0);
        chk("async_rst_cnt", 32'(start_cnt), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
